// File: rtl/pyrm_imem_pkg.sv
// Shared types and defaults for the instruction-memory arbiter and its
// per-requester response buffers.
package pyrm_imem_pkg;

    typedef enum logic {
        REQ_FETCH = 1'b0,
        REQ_LOAD  = 1'b1
    } req_id_e;

    localparam int MEM_AW_DEF       = 14;
    localparam int STARVE_LIMIT_DEF = 4;
    localparam int RESP_DEPTH       = 2;
    localparam int CNT_W            = 2;

endpackage

// File: rtl/pyrm_imem_resp_buf.sv
// Two-entry response FIFO with a valid/retry output port; one instance per
// read requester.
module pyrm_imem_resp_buf
    import pyrm_imem_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [31:0]      push_data,
    input  logic             resp_retry,
    output logic             resp_valid,
    output logic [31:0]      resp_data,
    output logic             pop,
    output logic [CNT_W-1:0] cnt
);

    logic [31:0] entry [RESP_DEPTH];
    logic        rd_ptr;
    logic        wr_ptr;
    logic        push_ok;

    assign resp_valid = (cnt != '0);
    assign resp_data  = resp_valid ? entry[rd_ptr] : '0;
    assign pop        = resp_valid && !resp_retry;
    // The arbiter never over-issues, but a push into a full, non-draining
    // buffer is still dropped rather than corrupting the head.
    assign push_ok    = push && ((cnt != CNT_W'(RESP_DEPTH)) || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            for (int i = 0; i < RESP_DEPTH; i++) begin
                entry[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                entry[wr_ptr] <= push_data;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push_ok, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/pyrm_imem_arb.sv
// Instruction-SRAM port arbiter between the fetch path and the loader/debug
// path, with starvation protection and per-requester ordered responses.
module pyrm_imem_arb
    import pyrm_imem_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int MEM_AW       = MEM_AW_DEF
) (
    input  logic              clk,
    input  logic              reset_n_pyri,
    input  logic              fetch_req_valid_pyri,
    input  logic [63:0]       fetch_req_addr_pyri,
    output logic              fetch_req_retry_pyro,
    output logic [31:0]       fetch_resp_data_pyro,
    output logic              fetch_resp_valid_pyro,
    input  logic              fetch_resp_retry_pyri,
    input  logic              ld_req_valid_pyri,
    input  logic              ld_req_we_pyri,
    input  logic [63:0]       ld_req_addr_pyri,
    input  logic [31:0]       ld_req_wdata_pyri,
    output logic              ld_req_retry_pyro,
    output logic [31:0]       ld_resp_data_pyro,
    output logic              ld_resp_valid_pyro,
    input  logic              ld_resp_retry_pyri,
    output logic              mem_req_valid_pyro,
    output logic              mem_we_pyro,
    output logic [MEM_AW-1:0] mem_addr_pyro,
    output logic [31:0]       mem_wdata_pyro,
    input  logic [31:0]       mem_rdata_pyri
);

    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    logic [SW-1:0]     starve_cnt;
    logic              inflight;
    req_id_e           inflight_owner;
    logic [CNT_W-1:0]  f_cnt;
    logic [CNT_W-1:0]  l_cnt;
    logic              f_pop;
    logic              l_pop;
    logic              f_push;
    logic              l_push;
    logic [2:0]        f_load;
    logic [2:0]        l_load;
    logic              f_elig;
    logic              l_elig;
    logic              f_cand;
    logic              l_cand;
    logic              starve_hit;
    logic              f_grant;
    logic              l_grant;
    logic              rd_grant;
    logic              unused_addr_bits;

    assign f_push = inflight && (inflight_owner == REQ_FETCH);
    assign l_push = inflight && (inflight_owner == REQ_LOAD);

    assign unused_addr_bits = ^{fetch_req_addr_pyri[63:MEM_AW+2], fetch_req_addr_pyri[1:0],
                                ld_req_addr_pyri[63:MEM_AW+2], ld_req_addr_pyri[1:0]};

    pyrm_imem_resp_buf u_fetch_buf (
        .clk        (clk),
        .rst_n      (reset_n_pyri),
        .push       (f_push),
        .push_data  (mem_rdata_pyri),
        .resp_retry (fetch_resp_retry_pyri),
        .resp_valid (fetch_resp_valid_pyro),
        .resp_data  (fetch_resp_data_pyro),
        .pop        (f_pop),
        .cnt        (f_cnt)
    );

    pyrm_imem_resp_buf u_ld_buf (
        .clk        (clk),
        .rst_n      (reset_n_pyri),
        .push       (l_push),
        .push_data  (mem_rdata_pyri),
        .resp_retry (ld_resp_retry_pyri),
        .resp_valid (ld_resp_valid_pyro),
        .resp_data  (ld_resp_data_pyro),
        .pop        (l_pop),
        .cnt        (l_cnt)
    );

    // A read may only be granted if its buffer is guaranteed a free slot when
    // the data lands; nothing is granted while reset is held.
    always_comb begin
        f_load     = {1'b0, f_cnt} + {2'b00, f_push} - {2'b00, f_pop};
        l_load     = {1'b0, l_cnt} + {2'b00, l_push} - {2'b00, l_pop};
        f_elig     = (f_load < 3'(RESP_DEPTH));
        l_elig     = ld_req_we_pyri || (l_load < 3'(RESP_DEPTH));
        f_cand     = reset_n_pyri && fetch_req_valid_pyri && f_elig;
        l_cand     = reset_n_pyri && ld_req_valid_pyri && l_elig;
        starve_hit = (starve_cnt == SW'(STARVE_LIMIT));
        l_grant    = l_cand && (!f_cand || starve_hit);
        f_grant    = f_cand && !l_grant;
        rd_grant   = f_grant || (l_grant && !ld_req_we_pyri);

        fetch_req_retry_pyro = !f_grant;
        ld_req_retry_pyro    = !l_grant;
        mem_req_valid_pyro   = f_grant || l_grant;
        mem_we_pyro          = l_grant && ld_req_we_pyri;
        mem_addr_pyro        = '0;
        mem_wdata_pyro       = '0;
        if (l_grant) begin
            mem_addr_pyro = ld_req_addr_pyri[MEM_AW+1:2];
            if (ld_req_we_pyri) begin
                mem_wdata_pyro = ld_req_wdata_pyri;
            end
        end else if (f_grant) begin
            mem_addr_pyro = fetch_req_addr_pyri[MEM_AW+1:2];
        end
    end

    always_ff @(posedge clk or negedge reset_n_pyri) begin
        if (!reset_n_pyri) begin
            inflight       <= 1'b0;
            inflight_owner <= REQ_FETCH;
        end else begin
            inflight       <= rd_grant;
            inflight_owner <= l_grant ? REQ_LOAD : REQ_FETCH;
        end
    end

    // An eligible loader that is not granted has necessarily lost to fetch.
    always_ff @(posedge clk or negedge reset_n_pyri) begin
        if (!reset_n_pyri) begin
            starve_cnt <= '0;
        end else if (l_grant) begin
            starve_cnt <= '0;
        end else if (l_cand && !starve_hit) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

endmodule
